reorder_buffer: RTL

//  16-entry circular reorder buffer (ROB) for the Tomasulo core; sits downstream of the RS and SLB.

---
 rtl/reorder_buffer_pkg.sv | 16 +
 rtl/reorder_buffer_lookup.sv | 38 +++
 rtl/reorder_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: geometry, entry type codes, empty-tag marker.
package reorder_buffer_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [31:0] NO_TAG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    T_ALU    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_JALR   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Combinational operand read from the ROB, forwarding same-cycle RS/SLB results.
import reorder_buffer_pkg::*;

module rob_lookup (
  input  logic [31:0]                q_tag,
  input  logic                       wb_valid,
  input  logic [31:0]                wb_tag,
  input  logic [31:0]                wb_value,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_tag,
  input  logic [31:0]                ld_value,
  input  logic [DEPTH-1:0]           done,
  input  logic [DEPTH-1:0][31:0]     value,
  output logic                       q_ready,
  output logic [31:0]                q_value
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    idx     = q_tag[IDX_W-1:0];
    q_ready = 1'b0;
    q_value = '0;
    if (q_tag != NO_TAG) begin
      if (wb_valid && (wb_tag == q_tag)) begin
        q_ready = 1'b1;
        q_value = wb_value;
      end else if (ld_valid && (ld_tag == q_tag)) begin
        q_ready = 1'b1;
        q_value = ld_value;
      end else if (done[idx]) begin
        q_ready = 1'b1;
        q_value = value[idx];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: tag allocation, result capture, in-order commit,
// and mispredict flush/redirect at commit.
import reorder_buffer_pkg::*;

module reorder_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_valid,
  output logic        alloc_ready,
  output logic [31:0] alloc_tag,
  input  logic [1:0]  alloc_type,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_pred,
  input  logic [31:0] q1_tag,
  input  logic [31:0] q2_tag,
  output logic        q1_ready,
  output logic        q2_ready,
  output logic [31:0] q1_value,
  output logic [31:0] q2_value,
  input  logic        wb_valid,
  input  logic [31:0] wb_tag,
  input  logic [31:0] wb_value,
  input  logic        wb_topc_valid,
  input  logic [31:0] wb_topc,
  input  logic        ld_valid,
  input  logic [31:0] ld_tag,
  input  logic [31:0] ld_value,
  output logic        cm_valid,
  output logic [31:0] cm_tag,
  output logic [4:0]  cm_rd,
  output logic [31:0] cm_value,
  output logic        cm_store,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  localparam logic [IDX_W-1:0] PTR_ONE = 1;
  localparam logic [IDX_W:0]   CNT_ONE = 1;

  rob_type_e              type_q [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic [31:0]            pred_q [DEPTH];
  logic [31:0]            topc_q [DEPTH];
  logic [DEPTH-1:0][31:0] value_q;
  logic [DEPTH-1:0]       busy_q;
  logic [DEPTH-1:0]       done_q;

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;

  logic             accept_in;
  logic             do_alloc;
  logic             do_commit;
  logic             mispredict;
  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W-1:0] ld_idx;

  // count never exceeds DEPTH, so its MSB alone marks "full"
  assign alloc_ready = ~count_q[IDX_W];
  assign alloc_tag   = {{(32-IDX_W){1'b0}}, tail_q};

  always_comb begin
    // inputs seen while flush is high belong to the squashed path
    accept_in  = ~flush;
    do_alloc   = alloc_valid && alloc_ready && accept_in;
    do_commit  = (count_q != '0) && done_q[head_q];
    mispredict = do_commit
                 && ((type_q[head_q] == T_BRANCH) || (type_q[head_q] == T_JALR))
                 && (topc_q[head_q] != pred_q[head_q]);
    wb_idx     = wb_tag[IDX_W-1:0];
    ld_idx     = ld_tag[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      cm_valid    <= 1'b0;
      cm_tag      <= '0;
      cm_rd       <= '0;
      cm_value    <= '0;
      cm_store    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else if (!rdy) begin
      cm_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      cm_valid <= do_commit;
      flush    <= mispredict;
      if (do_commit) begin
        cm_tag   <= {{(32-IDX_W){1'b0}}, head_q};
        cm_rd    <= ((type_q[head_q] == T_BRANCH) || (type_q[head_q] == T_STORE)) ? '0 : rd_q[head_q];
        cm_value <= value_q[head_q];
        cm_store <= (type_q[head_q] == T_STORE);
      end
      if (mispredict) begin
        redirect_pc <= topc_q[head_q];
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        busy_q      <= '0;
        done_q      <= '0;
      end else begin
        if (accept_in && wb_valid && busy_q[wb_idx]) begin
          value_q[wb_idx] <= wb_value;
          done_q[wb_idx]  <= 1'b1;
          if (wb_topc_valid)
            topc_q[wb_idx] <= wb_topc;
        end
        if (accept_in && ld_valid && busy_q[ld_idx]) begin
          value_q[ld_idx] <= ld_value;
          done_q[ld_idx]  <= 1'b1;
        end
        if (do_alloc) begin
          type_q[tail_q] <= rob_type_e'(alloc_type);
          rd_q[tail_q]   <= alloc_rd;
          pred_q[tail_q] <= alloc_pred;
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          tail_q         <= tail_q + PTR_ONE;
        end
        // retiring clears after the result writes so a late wb cannot revive the head
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
          head_q         <= head_q + PTR_ONE;
        end
        case ({do_alloc, do_commit})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  rob_lookup u_lookup_q1 (
    .q_tag    (q1_tag),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_value (wb_value),
    .ld_valid (ld_valid),
    .ld_tag   (ld_tag),
    .ld_value (ld_value),
    .done     (done_q),
    .value    (value_q),
    .q_ready  (q1_ready),
    .q_value  (q1_value)
  );

  rob_lookup u_lookup_q2 (
    .q_tag    (q2_tag),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_value (wb_value),
    .ld_valid (ld_valid),
    .ld_tag   (ld_tag),
    .ld_value (ld_value),
    .done     (done_q),
    .value    (value_q),
    .q_ready  (q2_ready),
    .q_value  (q2_value)
  );

endmodule
